// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmit sample feeder: FSM encoding,
// underrun fill modes and the underrun counter width.
package i2s_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int UNDERRUN_ZERO   = 0;
    localparam int UNDERRUN_REPEAT = 1;

    localparam int UCNT_W = 16;

endpackage

// File: rtl/i2s_pair_fifo.sv
// Synchronous FIFO of stereo pairs with wrap-bit pointers and an occupancy
// output. No read bypass: a written entry is visible the cycle after.
module i2s_pair_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_i) wptr_q <= wptr_q + 1'b1;
            if (rd_i) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset; occupancy is defined solely by the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/i2s_tx_sample_feeder.sv
// Buffers stereo pairs and hands one pair per frame to the I2S transmitter,
// popping on the mid-frame lrclk rise; starved pops are counted and filled.
module i2s_tx_sample_feeder
    import i2s_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int PRIME_LEVEL   = 4,
    parameter int UNDERRUN_MODE = UNDERRUN_ZERO,
    localparam int LW           = $clog2(DEPTH) + 1
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_left,
    input  logic [WIDTH-1:0]  in_right,
    input  logic              lrclk,
    output logic [WIDTH-1:0]  left_chan,
    output logic [WIDTH-1:0]  right_chan,
    output logic [LW-1:0]     level,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam logic [LW-1:0] PRIME_L = PRIME_LEVEL[LW-1:0];

    logic               lrclk_q;
    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   left_q, left_d, right_q, right_d;
    logic               und_q, und_d;
    logic [UCNT_W-1:0]  cnt_q, cnt_d;
    logic               full, empty, wr_en, rd_en, pop_evt, serve;
    logic [2*WIDTH-1:0] head;

    assign pop_evt  = lrclk & ~lrclk_q;
    assign in_ready = ~full & ~flush;
    assign wr_en    = in_valid & in_ready;
    // A flush or a falling enable in the same cycle wins over the pop.
    assign serve    = (state_q == ST_RUN) & enable & ~flush & pop_evt;
    assign rd_en    = serve & ~empty;

    i2s_pair_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (sclk),
        .rst_ni  (rst),
        .clr_i   (flush),
        .wr_i    (wr_en),
        .wdata_i ({in_left, in_right}),
        .rd_i    (rd_en),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (!flush && level >= PRIME_L) state_d = ST_RUN;
                ST_RUN:   if (flush) state_d = ST_PRIME;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        und_d   = 1'b0;
        cnt_d   = cnt_q;
        if (rd_en) begin
            {left_d, right_d} = head;
        end else if (serve) begin
            und_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (UNDERRUN_MODE == UNDERRUN_ZERO) begin
                left_d  = '0;
                right_d = '0;
            end
        end
    end

    // lrclk_q resets high so a lrclk already high at release is not an edge.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            lrclk_q <= 1'b1;
            state_q <= ST_IDLE;
            left_q  <= '0;
            right_q <= '0;
            und_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            lrclk_q <= lrclk;
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            und_q   <= und_d;
            cnt_q   <= cnt_d;
        end
    end

    assign left_chan    = left_q;
    assign right_chan   = right_q;
    assign underrun     = und_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_i2s_tx_sample_feeder.sv
// Bench for i2s_tx_sample_feeder: a zero-fill and a repeat-fill instance share
// stimulus and are compared against a queue-based reference model.
module tb_i2s_tx_sample_feeder;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int PL = 4;
    localparam int LW = 5;

    logic sclk = 1'b0, rst = 1'b0, enable = 1'b0, flush = 1'b0, in_valid = 1'b0, lrclk = 1'b0;
    logic [W-1:0] in_left = '0, in_right = '0;
    logic         rdy0, rdy1, u0, u1;
    logic [W-1:0] l0, r0, l1, r1;
    logic [LW-1:0] lv0, lv1;
    logic [15:0]  c0, c1;

    always #5 sclk = ~sclk;

    i2s_tx_sample_feeder #(.WIDTH(W), .DEPTH(D), .PRIME_LEVEL(PL), .UNDERRUN_MODE(0)) dut0 (
        .sclk(sclk), .rst(rst), .enable(enable), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy0), .in_left(in_left), .in_right(in_right), .lrclk(lrclk),
        .left_chan(l0), .right_chan(r0), .level(lv0), .underrun(u0), .underrun_cnt(c0));

    i2s_tx_sample_feeder #(.WIDTH(W), .DEPTH(D), .PRIME_LEVEL(PL), .UNDERRUN_MODE(1)) dut1 (
        .sclk(sclk), .rst(rst), .enable(enable), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy1), .in_left(in_left), .in_right(in_right), .lrclk(lrclk),
        .left_chan(l1), .right_chan(r1), .level(lv1), .underrun(u1), .underrun_cnt(c1));

    // Reference model: pair queue, playback phase (0 idle, 1 priming, 2 playing)
    logic [2*W-1:0] q[$];
    int           st, ecnt;
    bit           lr_prev, eund;
    logic [W-1:0] el0, er0, el1, er1;
    int           nvec = 0, nerr = 0;

    typedef struct {
        bit v; bit en; bit lr; int idx;
        int e_lvl; int e_idx; bit e_u;
    } vec_t;
    vec_t tbl[17];

    function automatic vec_t mk(bit v, bit en, bit lr, int idx, int e_lvl, int e_idx, bit e_u);
        vec_t t;
        t.v = v; t.en = en; t.lr = lr; t.idx = idx;
        t.e_lvl = e_lvl; t.e_idx = e_idx; t.e_u = e_u;
        return t;
    endfunction

    function automatic logic [W-1:0] lval(int i);
        return (i == 0) ? '0 : (32'h1000_0000 + W'(i));
    endfunction

    function automatic logic [W-1:0] rval(int i);
        return (i == 0) ? '0 : (32'h2000_0000 + W'(i));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        q.delete();
        st = 0; ecnt = 0; lr_prev = 1'b1; eund = 1'b0;
        el0 = '0; er0 = '0; el1 = '0; er1 = '0;
    endtask

    task automatic mstep();
        bit pop, acc, serve;
        int n0;
        logic [2*W-1:0] p;
        n0    = q.size();
        pop   = lrclk && !lr_prev;
        acc   = in_valid && (n0 < D) && !flush;
        serve = (st == 2) && enable && !flush && pop;
        eund  = 1'b0;
        if (serve) begin
            if (n0 > 0) begin
                p = q.pop_front();
                el0 = p[2*W-1:W]; er0 = p[W-1:0]; el1 = el0; er1 = er0;
            end else begin
                eund = 1'b1; el0 = '0; er0 = '0;
                if (ecnt < 65535) ecnt++;
            end
        end
        if (flush) q.delete();
        if (acc) q.push_back({in_left, in_right});
        if (!enable) st = 0;
        else if (st == 0) st = 1;
        else if (st == 1) begin
            if (!flush && n0 >= PL) st = 2;
        end else if (flush) st = 1;
        lr_prev = lrclk;
    endtask

    task automatic compare();
        bit erdy;
        erdy = (q.size() < D) && !flush;
        chk("level0", 64'(lv0), 64'(q.size()));
        chk("level1", 64'(lv1), 64'(q.size()));
        chk("ready0", 64'(rdy0), 64'(erdy));
        chk("ready1", 64'(rdy1), 64'(erdy));
        chk("left0", 64'(l0), 64'(el0));
        chk("right0", 64'(r0), 64'(er0));
        chk("left1", 64'(l1), 64'(el1));
        chk("right1", 64'(r1), 64'(er1));
        chk("underrun0", 64'(u0), 64'(eund));
        chk("underrun1", 64'(u1), 64'(eund));
        chk("cnt0", 64'(c0), 64'(ecnt));
        chk("cnt1", 64'(c1), 64'(ecnt));
    endtask

    task automatic step();
        @(posedge sclk);
        mstep();
        #1;
        compare();
    endtask

    initial begin
        int hp, hc, pwr;
        logic [W-1:0] first_l;

        tbl[0]  = mk(1, 0, 0, 1, 1, 0, 0);
        tbl[1]  = mk(1, 1, 0, 2, 2, 0, 0);
        tbl[2]  = mk(1, 1, 1, 3, 3, 0, 0);
        tbl[3]  = mk(1, 1, 0, 4, 4, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 4, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 4, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 3, 1, 0);
        tbl[7]  = mk(0, 1, 1, 0, 3, 1, 0);
        tbl[8]  = mk(0, 1, 0, 0, 3, 1, 0);
        tbl[9]  = mk(0, 1, 1, 0, 2, 2, 0);
        tbl[10] = mk(0, 1, 0, 0, 2, 2, 0);
        tbl[11] = mk(0, 1, 1, 0, 1, 3, 0);
        tbl[12] = mk(0, 1, 0, 0, 1, 3, 0);
        tbl[13] = mk(0, 1, 1, 0, 0, 4, 0);
        tbl[14] = mk(0, 1, 0, 0, 0, 4, 0);
        tbl[15] = mk(0, 1, 1, 0, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 0, 0, 0, 0);

        mreset();
        #12;
        compare();
        rst = 1'b1;

        // Prime, play four pairs, then underrun
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].v; enable = tbl[i].en; lrclk = tbl[i].lr;
            if (tbl[i].v) begin
                in_left = lval(tbl[i].idx); in_right = rval(tbl[i].idx);
            end
            step();
            chk("tbl_level", 64'(lv0), 64'(tbl[i].e_lvl));
            chk("tbl_left", 64'(l0), 64'(lval(tbl[i].e_idx)));
            chk("tbl_right", 64'(r0), 64'(rval(tbl[i].e_idx)));
            chk("tbl_underrun", 64'(u0), 64'(tbl[i].e_u));
        end
        chk("underrun_cnt_one", 64'(c0), 64'd1);
        chk("repeat_left", 64'(l1), 64'h1000_0004);
        chk("repeat_right", 64'(r1), 64'h2000_0004);

        // Fill to full with playback stopped
        enable = 1'b0; in_valid = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_left = $urandom; in_right = $urandom;
            step();
        end
        chk("full_ready", 64'(rdy0), 64'd0);
        chk("full_level", 64'(lv0), 64'd16);
        in_left = $urandom;
        step();
        chk("full_17th_dropped", 64'(lv0), 64'd16);
        in_valid = 1'b0; enable = 1'b1;
        step(); step();
        lrclk = 1'b0; step();
        lrclk = 1'b1; step();
        chk("ready_after_pop", 64'(rdy0), 64'd1);

        // Flush while playing
        flush = 1'b1; step();
        flush = 1'b0;
        chk("flush_level", 64'(lv0), 64'd0);
        lrclk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_left = $urandom; in_right = $urandom;
            step();
        end
        in_valid = 1'b0;

        // Write on every pop at level 8, across several pointer wraps
        for (int f = 0; f < 32; f++) begin
            lrclk = 1'b0; step(); step();
            lrclk = 1'b1; in_valid = 1'b1; in_left = $urandom; in_right = $urandom;
            step();
            in_valid = 1'b0;
            chk("concurrent_level", 64'(lv0), 64'd8);
            step();
        end

        // Enable low: outputs and count frozen over 10 frames
        enable = 1'b0;
        for (int f = 0; f < 10; f++) begin
            lrclk = 1'b0; step(); step();
            lrclk = 1'b1; step(); step();
        end
        enable = 1'b1;

        // Randomized traffic
        hp = 3; hc = 0; pwr = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) pwr = $urandom_range(1, 6);
            in_valid = ($urandom_range(0, 7) < pwr);
            in_left = $urandom; in_right = $urandom;
            flush = ($urandom_range(0, 120) == 0);
            enable = ($urandom_range(0, 150) != 0);
            if (++hc >= hp) begin
                hc = 0; lrclk = ~lrclk; hp = $urandom_range(2, 5);
            end
            step();
        end
        flush = 1'b0; enable = 1'b1; in_valid = 1'b0;

        // Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; lrclk = (i >= 3); in_left = $urandom; in_right = $urandom;
            step();
        end
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1 mreset();
        compare();
        lrclk = 1'b1;
        @(posedge sclk); @(posedge sclk);
        #3 rst = 1'b1;
        first_l = 32'hCAFE_0001;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4); in_left = first_l + W'(i); in_right = $urandom;
            step();
        end
        in_valid = 1'b0;
        chk("no_pop_after_reset", 64'(l0), 64'd0);
        lrclk = 1'b0; step();
        lrclk = 1'b1; step();
        chk("post_reset_pop", 64'(l0), 64'(first_l));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/i2s_tx_sample_feeder.md
Name: i2s_tx_sample_feeder

Overview:
Buffers stereo sample pairs from the audio source and presents them on left_chan/right_chan to the I2S transmitter, one pair per frame. It sits directly upstream of the I2S transmitter and uses that transmitter's lrclk output to pace its reads. A valid/ready write port absorbs bursty producers. Underruns are detected, counted and filled with a deterministic value.

Parameters:
WIDTH, 32, bits per channel sample
DEPTH, 16, FIFO depth in stereo pairs; must be a power of 2 and at least 2
PRIME_LEVEL, 4, FIFO level (1..DEPTH) required before playback starts
UNDERRUN_MODE, 0, fill on underrun: 0 = output zeros, 1 = repeat last pair

Ports:
sclk  in  1  bit clock; the only clock
rst  in  1  asynchronous, active-low reset
enable  in  1  playback enable
flush  in  1  synchronous FIFO clear, 1-cycle pulse
in_valid  in  1  write request
in_ready  out  1  FIFO can accept a pair
in_left  in  WIDTH  left sample to write
in_right  in  WIDTH  right sample to write
lrclk  in  1  word select from the I2S transmitter, sclk domain
left_chan  out  WIDTH  left sample to the transmitter
right_chan  out  WIDTH  right sample to the transmitter
level  out  $clog2(DEPTH)+1  current FIFO occupancy
underrun  out  1  one-cycle pulse on a starved pop
underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset values: left_chan=0, right_chan=0, level=0, underrun=0, underrun_cnt=0, state=IDLE, pointers=0, lrclk_q=1. Because lrclk_q resets to 1, no false edge is seen after reset. in_ready is 1 once reset is released.
- lrclk is already in the sclk domain, so it needs no synchronizer. It is registered once into lrclk_q.
- pop_evt = lrclk & ~lrclk_q, i.e. the rising edge, which is mid-frame. The transmitter latches at the frame start (lrclk falling), so outputs always have half a frame of setup.
- left_chan/right_chan change only on the cycle after pop_evt. Between pop events they hold constant.
- Write: a pair is accepted when in_valid & in_ready.
  - in_ready = ~full & ~flush.
  - Pointers are $clog2(DEPTH)+1 bits wide. The MSB is the wrap bit. full = (addresses equal and wrap bits differ). empty = (pointers equal).
  - A written pair becomes poppable on the next cycle. There is no bypass into the outputs.
- FSM states:
  - IDLE: when enable=1, go to PRIME.
  - PRIME: pop events are ignored and outputs hold. When level >= PRIME_LEVEL, go to RUN.
  - RUN: on pop_evt, if not empty, load the head pair into the outputs and advance rd_ptr. If empty, it is an underrun: outputs become 0 (mode 0) or hold (mode 1), underrun pulses high for 1 cycle, and underrun_cnt increments, saturating at 16'hFFFF. The state stays RUN after an underrun.
  - enable=0 in any state: go to IDLE on the next cycle. Outputs and the FIFO are kept.
- Flush: both pointers reset to 0 and level becomes 0. Any write in that cycle is dropped, since in_ready=0. Outputs and underrun_cnt are unchanged. If the state is RUN, it goes to PRIME.
- Simultaneous write and pop on a non-empty FIFO: both occur and level is unchanged.
- Write on an empty FIFO in the same cycle as pop_evt: the pop is an underrun, and the write lands in the FIFO.
- Asserting rst mid-operation clears everything immediately to the reset values.

Decomposition:
- Package i2s_pkg holds:
  - the state encoding IDLE/PRIME/RUN;
  - the constants UNDERRUN_ZERO=0 and UNDERRUN_REPEAT=1;
  - the underrun counter width of 16.
- Sub-module i2s_pair_fifo: a synchronous FIFO of width 2*WIDTH and depth DEPTH, with wrap-bit pointers and a level output. The feeder contains the edge detect, the FSM, the output registers and the counter.

Test Plan:
- Prime/run: write 4 pairs (L=32'h1000_0001..4, R=32'h2000_0001..4) and enable. There is no output change until level=4. The next 4 lrclk rises yield pairs 1..4 in order, each appearing 1 cycle after the rise, with underrun=0.
- Underrun: continue from the previous test with no further writes. The 5th rise gives outputs=0, an underrun pulse and cnt=1. Repeat with UNDERRUN_MODE=1: outputs hold pair 4.
- Full: write 16 pairs with no pops. in_ready falls after the 16th write and level=16. A 17th in_valid is not accepted. One pop brings in_ready back to 1 the next cycle.
- Concurrent: with level=8, hold in_valid=1 across a pop_evt. level stays 8 and output order is preserved across the pointer wrap (write 40 pairs total).
- Flush and enable: flush in RUN gives level=0, state PRIME and unchanged outputs. Dropping enable mid-stream leaves outputs frozen and cnt unchanged over 10 frames.
- Reset: assert rst low mid-frame. All outputs go to 0 asynchronously. After release with lrclk already high, no pop occurs until a genuine low-to-high transition.
